// File: rtl/sfifo_wr_arbiter_if.sv
// Write-side bundle shared by N producers, the write arbiter and one SFIFO write port.
// The arbiter takes the slave view; the producer/FIFO side takes the master view.
interface sfifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]         req_valid;
    logic [N*WIDTH-1:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [WIDTH-1:0]     fifo_data_in;
    logic                 busy;
    logic [$clog2(N)-1:0] grant_id;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, busy, grant_id
    );
endinterface

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter steering one of N valid/ready producers onto a FIFO write port.
// A grant lasts up to MAX_BURST beats; an IDLE cycle always separates consecutive grants.
module sfifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    sfifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] last, last_nxt;
    logic [CW-1:0]  beat_cnt, beat_cnt_nxt;

    logic             own_valid;
    logic [WIDTH-1:0] own_data;
    logic             transfer;
    logic             rr_hit;
    logic [IDW-1:0]   rr_pick;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_RST;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IDW'(i)) begin
                own_valid = bus.req_valid[i];
                own_data  = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Scan last+1, last+2, ... mod N; walking k downwards lets the nearest requester win.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && ((int'(last) + k) % N == i)) begin
                    rr_hit  = 1'b1;
                    rr_pick = IDW'(i);
                end
            end
        end
    end

    assign transfer = (state == GRANT) && own_valid && !bus.fifo_full;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (rr_hit) begin
                    state_nxt    = GRANT;
                    owner_nxt    = rr_pick;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (transfer) beat_cnt_nxt = beat_cnt + 1'b1;
                // A full-FIFO stall with valid held keeps the grant and the count.
                if (!own_valid || (transfer && beat_cnt == CNT_LAST)) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end
            end
        endcase
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_data_in = '0;
        if (state == GRANT) begin
            for (int i = 0; i < N; i++) begin
                if (owner == IDW'(i)) bus.req_ready[i] = !bus.fifo_full;
            end
            bus.fifo_wr_en   = own_valid && !bus.fifo_full;
            bus.fifo_data_in = own_data;
        end
    end

    assign bus.busy     = (state == GRANT);
    assign bus.grant_id = owner;
endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Self-checking bench for sfifo_wr_arbiter: directed scenarios plus a randomized run
// judged by a transaction-level model (round-robin winner, burst length, release rule).
module tb_sfifo_wr_arbiter;
    localparam int N         = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst;

    sfifo_wr_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    sfifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Producer side: requester i offers beat_val(i, seq[i]) while enabled and beats remain.
    logic [N-1:0]     en;
    logic             full_drv;
    int               remaining [N];
    logic [5:0]       seq [N];
    int               served [N];
    logic [WIDTH-1:0] fifo_q [$];

    logic [N-1:0]     obs_ready;
    logic             obs_wr;
    logic             obs_busy;
    logic [WIDTH-1:0] obs_data;
    logic [1:0]       obs_gid;

    // Transaction model: who should own the port, how many beats it has moved, who went last.
    bit           m_prev_busy;
    logic [N-1:0] m_prev_valid;
    bit           m_prev_own_valid;
    int           m_last;
    int           m_owner;
    int           m_beats;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] beat_val(input int i, input logic [5:0] s);
        return WIDTH'(i * 64) | {2'b00, s};
    endfunction

    task automatic model_reset();
        m_prev_busy      = 1'b0;
        m_prev_valid     = '0;
        m_prev_own_valid = 1'b0;
        m_last           = N - 1;
        m_owner          = 0;
        m_beats          = 0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        en            = '0;
        full_drv      = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]       = '0;
            remaining[i] = 0;
            served[i]    = 0;
        end
        fifo_q.delete();
        model_reset();
        @(posedge clk);
        #4;
        check("reset_busy",  bus.busy,         0);
        check("reset_gid",   bus.grant_id,     0);
        check("reset_ready", bus.req_ready,    0);
        check("reset_wr",    bus.fifo_wr_en,   0);
        check("reset_data",  bus.fifo_data_in, 0);
        @(posedge clk);
    endtask

    // One clock: drive just after the edge, optionally pulse reset mid-cycle, sample before the next edge.
    task automatic cycle(input bit do_rst);
        logic [N-1:0]       v;
        logic [N*WIDTH-1:0] d;
        logic [N-1:0]       exp_rdy;
        bit                 rel;
        int                 w;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = en[i] && (remaining[i] > 0);
            d[i*WIDTH +: WIDTH] = beat_val(i, seq[i]);
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full_drv;
        #1;
        if (do_rst) rst = 1'b1;
        #2;
        obs_ready = bus.req_ready;
        obs_wr    = bus.fifo_wr_en;
        obs_busy  = bus.busy;
        obs_data  = bus.fifo_data_in;
        obs_gid   = bus.grant_id;

        if (do_rst) begin
            check("async_rst_busy",  obs_busy,  0);
            check("async_rst_ready", obs_ready, 0);
            check("async_rst_wr",    obs_wr,    0);
            check("async_rst_data",  obs_data,  0);
            model_reset();
            return;
        end

        if (m_prev_busy) begin
            rel = !m_prev_own_valid || (m_beats == MAX_BURST);
            check("release", obs_busy, !rel);
            if (rel) m_last = m_owner;
            else     check("grant_hold", obs_gid, m_owner);
        end else begin
            w = rr_winner(m_prev_valid, m_last);
            check("grant_start", obs_busy, w >= 0);
            if (w >= 0) begin
                check("grant_id", obs_gid, w);
                m_owner = w;
                m_beats = 0;
            end
        end

        if (obs_busy) begin
            exp_rdy = '0;
            if (!full_drv) exp_rdy[m_owner] = 1'b1;
            check("ready_vec", obs_ready, exp_rdy);
            check("wr_en", obs_wr, v[m_owner] && !full_drv);
            m_prev_own_valid = v[m_owner];
        end else begin
            check("idle_ready", obs_ready, 0);
            check("idle_wr",    obs_wr,    0);
            check("idle_data",  obs_data,  0);
        end

        if (obs_wr) begin
            check("wr_data", obs_data, beat_val(m_owner, seq[m_owner]));
            fifo_q.push_back(obs_data);
        end
        for (int i = 0; i < N; i++) begin
            if (obs_ready[i] && v[i]) begin
                seq[i]++;
                remaining[i]--;
                served[i]++;
                if (obs_busy && i == m_owner) m_beats++;
            end
        end
        m_prev_busy  = obs_busy;
        m_prev_valid = v;
    endtask

    initial begin
        logic [9:0]       t1_busy;
        logic [9:0]       t1_wr;
        logic [8:0]       t3_busy;
        logic [8:0]       t3_wr;
        int               exp_order [5];
        int               gq [$];
        bit               prevb;
        int               b;
        logic [WIDTH-1:0] exp_b;

        // Single requester, 6 beats: bursts of 4 then 2 with one IDLE cycle between.
        do_reset();
        t1_busy = 10'b0111011110;
        t1_wr   = 10'b0011011110;
        en = 4'b0001;
        remaining[0] = 6;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0);
            check($sformatf("t1_busy_c%0d", c), obs_busy, t1_busy[c]);
            check($sformatf("t1_wr_c%0d", c),   obs_wr,   t1_wr[c]);
        end
        check("t1_fifo_len", fifo_q.size(), 6);
        for (int j = 0; j < 6 && j < fifo_q.size(); j++)
            check($sformatf("t1_fifo_%0d", j), fifo_q[j], beat_val(0, 6'(j)));

        // All four requesting: grants 0,1,2,3,0 with four beats each.
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        en = 4'b1111;
        for (int i = 0; i < N; i++) remaining[i] = 8;
        gq.delete();
        prevb = 1'b0;
        for (int c = 0; c < 25; c++) begin
            cycle(1'b0);
            if (obs_busy && !prevb) gq.push_back(int'(obs_gid));
            prevb = obs_busy;
        end
        check("t2_grant_cnt", gq.size(), 5);
        for (int g = 0; g < 5 && g < gq.size(); g++)
            check($sformatf("t2_grant_%0d", g), gq[g], exp_order[g]);
        check("t2_fifo_len", fifo_q.size(), 20);
        for (int j = 0; j < 20 && j < fifo_q.size(); j++) begin
            b = j / 4;
            exp_b = beat_val(b % 4, 6'((b / 4) * 4 + j % 4));
            check($sformatf("t2_fifo_%0d", j), fifo_q[j], exp_b);
        end

        // FIFO full for three cycles in the middle of requester 2's burst.
        do_reset();
        t3_busy = 9'b011111110;
        t3_wr   = 9'b011000110;
        en = 4'b0100;
        remaining[2] = 4;
        for (int c = 0; c < 9; c++) begin
            full_drv = (c >= 3 && c <= 5);
            cycle(1'b0);
            check($sformatf("t3_busy_c%0d", c), obs_busy, t3_busy[c]);
            check($sformatf("t3_wr_c%0d", c),   obs_wr,   t3_wr[c]);
            if (c >= 3 && c <= 5) check($sformatf("t3_ready_c%0d", c), obs_ready, 0);
        end
        full_drv = 1'b0;
        check("t3_fifo_len", fifo_q.size(), 4);
        for (int j = 0; j < 4 && j < fifo_q.size(); j++)
            check($sformatf("t3_fifo_%0d", j), fifo_q[j], beat_val(2, 6'(j)));

        // Requester 1 drops valid after 2 beats; waiting 3 beats waiting 0.
        do_reset();
        en = 4'b0010;
        remaining[0] = 4;
        remaining[1] = 2;
        remaining[3] = 4;
        cycle(1'b0);
        cycle(1'b0);
        check("t4_gid_c1", obs_gid, 1);
        en = 4'b1011;
        cycle(1'b0);
        cycle(1'b0);
        check("t4_busy_c3", obs_busy, 1);
        check("t4_wr_c3",   obs_wr,   0);
        cycle(1'b0);
        check("t4_busy_c4", obs_busy, 0);
        cycle(1'b0);
        check("t4_busy_c5", obs_busy, 1);
        check("t4_gid_c5",  obs_gid,  3);

        // Reset pulsed during requester 3's burst after two beats.
        do_reset();
        en = 4'b1000;
        remaining[0] = 4;
        remaining[3] = 4;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        check("t5_fifo_len", fifo_q.size(), 2);
        for (int j = 0; j < 2 && j < fifo_q.size(); j++)
            check($sformatf("t5_fifo_%0d", j), fifo_q[j], beat_val(3, 6'(j)));
        en = 4'b1001;
        cycle(1'b0);
        check("t5_idle_after_rst", obs_busy, 0);
        cycle(1'b0);
        check("t5_regrant_busy", obs_busy, 1);
        check("t5_regrant_gid",  obs_gid,  0);

        // Randomized valids and full flag, judged by the model inside cycle().
        do_reset();
        for (int i = 0; i < N; i++) remaining[i] = 1000000;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 99) < 85);
            full_drv = ($urandom_range(0, 99) < 25);
            cycle(1'b0);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("rand_served_%0d", i), served[i] > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
